// File: rtl/mem_arbiter.sv
// Purpose: shares one memory port between the instruction (I) and data (D) request ports.
// Latency: startReqX -> memStartReq 2 cycles; memReqFinish -> reqFinishX 1 cycle.
// Backpressure: one request held per port; extra startReqX while pending is dropped.
// Config: define MEM_ARB_RR_EN to alternate ties (default: D wins ties).
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  // instruction-fetch port (read-only)
  input  logic              startReqI,
  input  logic [ADDR_W-1:0] inAddrI,
  output logic              reqFinishI,
  output logic [DATA_W-1:0] outDataI,
  // data port
  input  logic              startReqD,
  input  logic              isRdD,
  input  logic [ADDR_W-1:0] inAddrD,
  input  logic [DATA_W-1:0] inDataD,
  output logic              reqFinishD,
  output logic [DATA_W-1:0] outDataD,
  // memory port
  output logic              memStartReq,
  output logic              memIsRd,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memInData,
  input  logic              memReqFinish,
  input  logic [DATA_W-1:0] memOutData
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Per-port request holding registers.
  logic              pend_i;
  logic              pend_d;
  logic [ADDR_W-1:0] lat_addr_i;
  logic [ADDR_W-1:0] lat_addr_d;
  logic              lat_rd_d;
  logic [DATA_W-1:0] lat_data_d;

  // Decoded FSM events for the current cycle.
  logic grant_i;
  logic grant_d;
  logic done_i;
  logic done_d;

  // A port may capture when idle, or when its own request completes this
  // cycle: the new capture overrides the clear of the old one.
  logic capture_i;
  logic capture_d;

  assign capture_i = startReqI && (!pend_i || done_i);
  assign capture_d = startReqD && (!pend_d || done_d);

`ifdef MEM_ARB_RR_EN
  // 1 = the most recent grant went to D; reset value makes the first tie go to I.
  logic last_grant_d;

  // Track which port was granted last so ties can alternate.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_d <= 1'b1;
    end else if (grant_i) begin
      last_grant_d <= 1'b0;
    end else if (grant_d) begin
      last_grant_d <= 1'b1;
    end
  end
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and grant/complete decode; a completion in IDLE is ignored.
  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    done_i    = 1'b0;
    done_d    = 1'b0;
    case (state)
      IDLE: begin
        if (pend_i && pend_d) begin
`ifdef MEM_ARB_RR_EN
          if (last_grant_d) begin
            grant_i = 1'b1;
          end else begin
            grant_d = 1'b1;
          end
`else
          grant_d = 1'b1;
`endif
        end else if (pend_d) begin
          grant_d = 1'b1;
        end else if (pend_i) begin
          grant_i = 1'b1;
        end
        if (grant_i) begin
          state_nxt = BUSY_I;
        end else if (grant_d) begin
          state_nxt = BUSY_D;
        end
      end
      BUSY_I: begin
        if (memReqFinish) begin
          done_i    = 1'b1;
          state_nxt = IDLE;
        end
      end
      BUSY_D: begin
        if (memReqFinish) begin
          done_d    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // I request latch: pending flag plus the address sampled with startReqI.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_i     <= 1'b0;
      lat_addr_i <= '0;
    end else if (capture_i) begin
      pend_i     <= 1'b1;
      lat_addr_i <= inAddrI;
    end else if (done_i) begin
      pend_i     <= 1'b0;
    end
  end

  // D request latch: pending flag plus address, direction and write data.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_d     <= 1'b0;
      lat_addr_d <= '0;
      lat_rd_d   <= 1'b0;
      lat_data_d <= '0;
    end else if (capture_d) begin
      pend_d     <= 1'b1;
      lat_addr_d <= inAddrD;
      lat_rd_d   <= isRdD;
      lat_data_d <= inDataD;
    end else if (done_d) begin
      pend_d     <= 1'b0;
    end
  end

  // Memory-side outputs: one-cycle start pulse; command fields held until the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      memStartReq <= 1'b0;
      memIsRd     <= 1'b0;
      memAddr     <= '0;
      memInData   <= '0;
    end else begin
      memStartReq <= grant_i || grant_d;
      if (grant_i) begin
        memIsRd   <= 1'b1;
        memAddr   <= lat_addr_i;
        memInData <= '0;
      end else if (grant_d) begin
        memIsRd   <= lat_rd_d;
        memAddr   <= lat_addr_d;
        memInData <= lat_data_d;
      end
    end
  end

  // I completion: pulse and capture read data (I is always a read).
  always_ff @(posedge clk) begin
    if (rst) begin
      reqFinishI <= 1'b0;
      outDataI   <= '0;
    end else begin
      reqFinishI <= done_i;
      if (done_i) begin
        outDataI <= memOutData;
      end
    end
  end

  // D completion: pulse always; read data only replaced on reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      reqFinishD <= 1'b0;
      outDataD   <= '0;
    end else begin
      reqFinishD <= done_d;
      if (done_d && lat_rd_d) begin
        outDataD <= memOutData;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic, all cycles
// compared against a transaction-level reference model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        startReqI;
  logic [15:0] inAddrI;
  logic        reqFinishI;
  logic [63:0] outDataI;
  logic        startReqD;
  logic        isRdD;
  logic [15:0] inAddrD;
  logic [63:0] inDataD;
  logic        reqFinishD;
  logic [63:0] outDataD;
  logic        memStartReq;
  logic        memIsRd;
  logic [15:0] memAddr;
  logic [63:0] memInData;
  logic        memReqFinish;
  logic [63:0] memOutData;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .startReqI(startReqI), .inAddrI(inAddrI),
    .reqFinishI(reqFinishI), .outDataI(outDataI),
    .startReqD(startReqD), .isRdD(isRdD), .inAddrD(inAddrD), .inDataD(inDataD),
    .reqFinishD(reqFinishD), .outDataD(outDataD),
    .memStartReq(memStartReq), .memIsRd(memIsRd), .memAddr(memAddr),
    .memInData(memInData), .memReqFinish(memReqFinish), .memOutData(memOutData)
  );

  // Reference model: one held request per port (0 = I, 1 = D), an owner
  // of the memory (-1 = none) and the expected registered outputs.
  typedef struct packed {
    logic [15:0] addr;
    logic        rd;
    logic [63:0] data;
  } req_t;

  req_t        held [2];
  bit          pend [2];
  int          owner;
  int          last;
  bit          e_fin [2];
  logic [63:0] e_out [2];
  bit          e_ms;
  bit          e_mrd;
  logic [15:0] e_maddr;
  logic [63:0] e_mdata;

  int n_checks = 0;
  int n_pass   = 0;
  int mem_cnt  = -1;
  bit auto_mem = 1'b0;
  int starts;

  function automatic void model_reset();
    pend[0] = 1'b0; pend[1] = 1'b0;
    held[0] = '0;   held[1] = '0;
    owner   = -1;
    last    = 1;
    e_fin[0] = 1'b0; e_fin[1] = 1'b0;
    e_out[0] = '0;   e_out[1] = '0;
    e_ms = 1'b0; e_mrd = 1'b0; e_maddr = '0; e_mdata = '0;
  endfunction

  function automatic void model_edge();
    bit   was [2];
    bit   start [2];
    req_t nreq [2];
    int   fin;
    int   win;
    was[0] = pend[0]; was[1] = pend[1];
    start[0] = startReqI; start[1] = startReqD;
    nreq[0] = '{addr: inAddrI, rd: 1'b1, data: 64'h0};
    nreq[1] = '{addr: inAddrD, rd: isRdD, data: inDataD};
    e_fin[0] = 1'b0; e_fin[1] = 1'b0; e_ms = 1'b0;
    fin = -1;
    if (owner >= 0 && memReqFinish) begin
      fin = owner;
      e_fin[fin] = 1'b1;
      if (held[fin].rd) e_out[fin] = memOutData;
      pend[fin] = 1'b0;
      owner = -1;
    end else if (owner < 0 && (was[0] || was[1])) begin
      if (was[0] && was[1]) begin
`ifdef MEM_ARB_RR_EN
        win = 1 - last;
`else
        win = 1;
`endif
      end else begin
        win = was[0] ? 0 : 1;
      end
      e_ms = 1'b1;
      e_maddr = held[win].addr;
      e_mrd   = held[win].rd;
      e_mdata = held[win].data;
      owner = win;
      last  = win;
    end
    for (int p = 0; p < 2; p++) begin
      if (start[p] && (!was[p] || fin == p)) begin
        pend[p] = 1'b1;
        held[p] = nreq[p];
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic set_idle();
    startReqI = 1'b0;
    startReqD = 1'b0;
    memReqFinish = 1'b0;
  endtask

  // One clock: optional memory responder, model update, then compare all outputs.
  task automatic cyc();
    if (auto_mem) begin
      if (rst) mem_cnt = -1;
      else if (e_ms) mem_cnt = $urandom_range(0, 3);
      memReqFinish = 1'b0;
      if (mem_cnt == 0) begin
        memReqFinish = 1'b1;
        memOutData = {$urandom, $urandom};
        mem_cnt = -1;
      end else if (mem_cnt > 0) begin
        mem_cnt--;
      end else if (owner < 0 && $urandom_range(0, 7) == 0) begin
        memReqFinish = 1'b1;
        memOutData = {$urandom, $urandom};
      end
    end
    if (rst) model_reset();
    else     model_edge();
    @(posedge clk);
    @(negedge clk);
    chk("reqFinishI",  reqFinishI,  e_fin[0]);
    chk("reqFinishD",  reqFinishD,  e_fin[1]);
    chk("outDataI",    outDataI,    e_out[0]);
    chk("outDataD",    outDataD,    e_out[1]);
    chk("memStartReq", memStartReq, e_ms);
    chk("memIsRd",     memIsRd,     e_mrd);
    chk("memAddr",     memAddr,     e_maddr);
    chk("memInData",   memInData,   e_mdata);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_reqFinishI"},  reqFinishI,  0);
    chk({tag, "_reqFinishD"},  reqFinishD,  0);
    chk({tag, "_outDataI"},    outDataI,    0);
    chk({tag, "_outDataD"},    outDataD,    0);
    chk({tag, "_memStartReq"}, memStartReq, 0);
    chk({tag, "_memIsRd"},     memIsRd,     0);
    chk({tag, "_memAddr"},     memAddr,     0);
    chk({tag, "_memInData"},   memInData,   0);
  endtask

  // Simultaneous I and D requests; 'first' is the port expected to win.
  task automatic tie(input int first, input string tag);
    logic [15:0] a_first;
    logic [15:0] a_second;
    a_first  = (first == 0) ? 16'h0100 : 16'h0200;
    a_second = (first == 0) ? 16'h0200 : 16'h0100;
    startReqI = 1'b1; inAddrI = 16'h0100;
    startReqD = 1'b1; isRdD = 1'b1; inAddrD = 16'h0200; inDataD = 64'h0;
    cyc();
    set_idle();
    cyc();
    chk({tag, "_first_start"}, memStartReq, 1);
    chk({tag, "_first_addr"},  memAddr, a_first);
    cyc(); cyc(); cyc();
    memReqFinish = 1'b1; memOutData = {$urandom, $urandom};
    cyc();
    chk({tag, "_first_fin"}, (first == 0) ? reqFinishI : reqFinishD, 1);
    memReqFinish = 1'b0;
    cyc();
    chk({tag, "_second_start"}, memStartReq, 1);
    chk({tag, "_second_addr"},  memAddr, a_second);
    cyc(); cyc(); cyc();
    memReqFinish = 1'b1; memOutData = {$urandom, $urandom};
    cyc();
    chk({tag, "_second_fin"}, (first == 0) ? reqFinishD : reqFinishI, 1);
    set_idle();
    cyc();
  endtask

  initial begin
    set_idle();
    inAddrI = '0; isRdD = 1'b0; inAddrD = '0; inDataD = '0; memOutData = '0;
    rst = 1'b1;
    model_reset();
    @(negedge clk);

    // Reset for two cycles, then a stray completion in IDLE.
    cyc(); cyc();
    chk_all_zero("reset");
    rst = 1'b0;
    memReqFinish = 1'b1; memOutData = 64'hA5A5_A5A5_5A5A_5A5A;
    cyc();
    chk("idle_fin_I", reqFinishI, 0);
    chk("idle_fin_D", reqFinishD, 0);
    set_idle();
    cyc();

    // Single I read.
    startReqI = 1'b1; inAddrI = 16'h0010;
    cyc();
    set_idle();
    cyc();
    chk("i_start", memStartReq, 1);
    chk("i_addr",  memAddr, 16'h0010);
    chk("i_isrd",  memIsRd, 1);
    cyc(); cyc(); cyc();
    memReqFinish = 1'b1; memOutData = 64'h1122_3344_5566_7788;
    cyc();
    chk("i_fin",   reqFinishI, 1);
    chk("i_data",  outDataI, 64'h1122_3344_5566_7788);
    chk("i_fin_d", reqFinishD, 0);
    set_idle();
    cyc();

    // D write finished in the same cycle as its memStartReq.
    startReqD = 1'b1; isRdD = 1'b0; inAddrD = 16'h8000; inDataD = 64'hDEAD_BEEF_0000_0000;
    cyc();
    set_idle();
    cyc();
    chk("d_isrd",  memIsRd, 0);
    chk("d_addr",  memAddr, 16'h8000);
    chk("d_wdata", memInData, 64'hDEAD_BEEF_0000_0000);
    memReqFinish = 1'b1; memOutData = 64'hFFFF_0000_FFFF_0000;
    cyc();
    chk("d_fin",   reqFinishD, 1);
    chk("d_hold",  outDataD, 0);
    set_idle();
    cyc();

    // Ties: second tie follows a lone I grant so alternation points at D.
`ifdef MEM_ARB_RR_EN
    tie(0, "tie1");
`else
    tie(1, "tie1");
`endif
    startReqI = 1'b1; inAddrI = 16'h0300;
    cyc();
    set_idle();
    cyc();
    memReqFinish = 1'b1; memOutData = {$urandom, $urandom};
    cyc();
    set_idle();
    cyc();
    tie(1, "tie2");

    // Reset while BUSY_D drops the request silently.
    startReqD = 1'b1; isRdD = 1'b1; inAddrD = 16'h0400;
    cyc();
    set_idle();
    cyc(); cyc(); cyc();
    rst = 1'b1;
    cyc();
    chk_all_zero("midrst");
    rst = 1'b0;
    cyc();
    memReqFinish = 1'b1; memOutData = {$urandom, $urandom};
    cyc();
    chk("midrst_no_fin", reqFinishD, 0);
    set_idle();
    cyc();

    // Second startReqI while pending is ignored.
    starts = 0;
    startReqI = 1'b1; inAddrI = 16'h0004;
    cyc();
    starts += int'(memStartReq);
    inAddrI = 16'h0008;
    cyc();
    starts += int'(memStartReq);
    chk("dup_addr", memAddr, 16'h0004);
    set_idle();
    for (int k = 0; k < 6; k++) begin
      cyc();
      starts += int'(memStartReq);
    end
    chk("dup_count", starts, 1);
    memReqFinish = 1'b1; memOutData = {$urandom, $urandom};
    cyc();
    set_idle();
    cyc();

    // Random traffic with a responding memory and occasional resets.
    auto_mem = 1'b1;
    for (int k = 0; k < 800; k++) begin
      rst       = ($urandom_range(0, 255) == 0);
      startReqI = ($urandom_range(0, 3) == 0);
      inAddrI   = 16'($urandom);
      startReqD = ($urandom_range(0, 3) == 0);
      isRdD     = 1'($urandom);
      inAddrD   = 16'($urandom);
      inDataD   = {$urandom, $urandom};
      cyc();
    end
    rst = 1'b0;
    startReqI = 1'b0;
    startReqD = 1'b0;
    for (int k = 0; k < 30; k++) cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
